// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
//   Shared types and constants for counter_pair_sequencer and its helpers.
//   - state_t : sequencer FSM states
//   - OP_*    : command opcodes carried on cmd_op
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    SNAP  = 3'd3,
    DUMP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_SETDUR = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_DUMP   = 2'd3;

endpackage

// File: rtl/byte_serializer.sv
// byte_serializer
//   Streams a WIDTH-bit word out as WIDTH/8 bytes, most significant byte
//   first, on a valid/ready port.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   load         capture load_data and start streaming next cycle
//   load_data    word to stream
//   out_valid    current byte valid
//   out_data     current byte (held while stalled)
//   out_ready    consumer ready
//   last_taken   final byte is being handed over this cycle
module byte_serializer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             last_taken
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             valid_reg;
  logic             take;

  assign take       = valid_reg && out_ready;
  assign last_taken = take && (idx_reg == LAST_IDX);
  assign out_valid  = valid_reg;
  // The word shifts left as bytes are taken, so the top byte is always current.
  assign out_data   = shift_reg[WIDTH-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      idx_reg   <= '0;
      valid_reg <= 1'b1;
    end else if (take) begin
      shift_reg <= shift_reg << 8;
      if (idx_reg == LAST_IDX) begin
        idx_reg   <= '0;
        valid_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_pair_sequencer.sv
// counter_pair_sequencer
//   Command-driven sequencer for an external up-counter / down-counter (alt)
//   pair: programs a run length, clears cnt while seeding alt, runs both for
//   the programmed number of cycles, snapshots them and streams a snapshot
//   out MSB byte first.
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cmd_valid/op/data/ready  command channel (accepted only in IDLE)
//   cnt_clr, cnt_en          up-counter clear / increment
//   alt_load, alt_en         alt load-from-cnt / decrement
//   cnt_value, alt_value     live counter values
//   out_valid/data/ready     snapshot byte stream
//   busy                     not IDLE
//   done                     one-cycle pulse while snapshotting
module counter_pair_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_data,
  output logic             cmd_ready,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             alt_load,
  output logic             alt_en,
  input  logic [WIDTH-1:0] cnt_value,
  input  logic [WIDTH-1:0] alt_value,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] dur_reg;
  logic [DUR_W-1:0] rem_reg;
  logic [WIDTH-1:0] snap_cnt_reg, snap_alt_reg;
  logic             cnt_clr_reg, cnt_en_reg, alt_load_reg, alt_en_reg, done_reg;
  logic             cmd_accept;
  logic             ser_load, ser_last_taken;
  logic [WIDTH-1:0] ser_word;

  assign cmd_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign cmd_accept = cmd_valid && cmd_ready;

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          case (cmd_op)
            OP_CLEAR: state_next = CLEAR;
            OP_RUN:   state_next = (dur_reg == '0) ? SNAP : RUN;
            OP_DUMP:  state_next = DUMP;
            default:  state_next = IDLE;
          endcase
        end
      end
      CLEAR:   state_next = IDLE;
      // rem was loaded with dur on entry, so leaving at rem==1 gives dur cycles
      RUN:     state_next = (rem_reg == DUR_W'(1)) ? SNAP : RUN;
      SNAP:    state_next = IDLE;
      DUMP:    state_next = ser_last_taken ? IDLE : DUMP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Control outputs are flops decoded from the state being entered, so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clr_reg  <= 1'b0;
      alt_load_reg <= 1'b0;
      cnt_en_reg   <= 1'b0;
      alt_en_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      cnt_clr_reg  <= (state_next == CLEAR);
      alt_load_reg <= (state_next == CLEAR);
      cnt_en_reg   <= (state_next == RUN);
      alt_en_reg   <= (state_next == RUN);
      done_reg     <= (state_next == SNAP);
    end
  end

  assign cnt_clr  = cnt_clr_reg;
  assign alt_load = alt_load_reg;
  assign cnt_en   = cnt_en_reg;
  assign alt_en   = alt_en_reg;
  assign done     = done_reg;

  // Run length, remaining count and snapshots
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_reg      <= '0;
      rem_reg      <= '0;
      snap_cnt_reg <= '0;
      snap_alt_reg <= '0;
    end else begin
      if (cmd_accept && cmd_op == OP_SETDUR) begin
        // Byte-wide shift-in: the most recent DUR_W/8 bytes form dur.
        dur_reg <= (dur_reg << 8) | DUR_W'(cmd_data);
      end
      if (cmd_accept && cmd_op == OP_RUN) begin
        rem_reg <= dur_reg;
      end else if (state_reg == RUN) begin
        rem_reg <= rem_reg - DUR_W'(1);
      end
      if (state_reg == SNAP) begin
        snap_cnt_reg <= cnt_value;
        snap_alt_reg <= alt_value;
      end
    end
  end

  assign ser_load = cmd_accept && (cmd_op == OP_DUMP);
  assign ser_word = cmd_data[0] ? snap_alt_reg : snap_cnt_reg;

  byte_serializer #(
    .WIDTH(WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_data (ser_word),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .last_taken(ser_last_taken)
  );

endmodule

// File: tb/tb_counter_pair_sequencer.sv
// tb_counter_pair_sequencer
//   Directed and randomized checks of counter_pair_sequencer. The counter
//   datapath is modelled as two registers; expected snapshots come from
//   plain arithmetic on the command history.
module tb_counter_pair_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH = 64;
  localparam int DUR_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [7:0]       cmd_data = 8'd0;
  logic             cmd_ready;
  logic             cnt_clr, cnt_en, alt_load, alt_en;
  logic [WIDTH-1:0] cnt_m = '0;
  logic [WIDTH-1:0] alt_m = '0;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready = 1'b0;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  // Monitor counters (written only by the monitor)
  int         en_total = 0, clr_total = 0, done_total = 0, valid_total = 0;
  int         hold_err = 0, en_at_clr = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] byte_q[$];

  // Expected state, derived from the command history
  logic [63:0] exp_cnt = '0, exp_alt = '0, exp_snap_cnt = '0, exp_snap_alt = '0;

  always #5 clk = ~clk;

  counter_pair_sequencer #(.WIDTH(WIDTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .alt_load(alt_load), .alt_en(alt_en),
    .cnt_value(cnt_m), .alt_value(alt_m),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  // External counter datapath
  always @(posedge clk) begin
    if (cnt_clr) cnt_m <= '0;
    else if (cnt_en) cnt_m <= cnt_m + 1'b1;
    if (alt_load) alt_m <= cnt_m;
    else if (alt_en) alt_m <= alt_m - 1'b1;
  end

  // Mid-cycle monitor: inputs change at posedge+1, so values seen here are
  // what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_en) en_total++;
      if (cnt_clr) begin clr_total++; en_at_clr = en_total; end
      if (done) done_total++;
      if (out_valid) valid_total++;
      if (out_valid && out_ready) byte_q.push_back(out_data);
      if (prev_stall && (!out_valid || out_data !== prev_data)) hold_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("cmd_accepted", ok, 1'b1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready && !out_valid) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    check("wait_idle", ok, 1'b1);
  endtask

  task automatic do_clear();
    int c0;
    c0 = clr_total;
    send_cmd(OP_CLEAR, 8'h00);
    wait_idle();
    check("clear_pulses", 64'(clr_total - c0), 64'd1);
    exp_alt = exp_cnt;
    exp_cnt = '0;
  endtask

  // Program run length d (optionally after a discarded leading byte), then RUN.
  task automatic do_run(input int d, input bit extra, input string tag);
    int e0, d0;
    e0 = en_total; d0 = done_total;
    if (extra) send_cmd(OP_SETDUR, 8'($urandom));
    send_cmd(OP_SETDUR, 8'(d >> 8));
    send_cmd(OP_SETDUR, 8'(d));
    send_cmd(OP_RUN, 8'($urandom));
    wait_idle();
    check({tag, "_en_cycles"}, 64'(en_total - e0), 64'(d));
    check({tag, "_done_pulses"}, 64'(done_total - d0), 64'd1);
    exp_cnt = exp_cnt + 64'(d);
    exp_alt = exp_alt - 64'(d);
    exp_snap_cnt = exp_cnt;
    exp_snap_alt = exp_alt;
  endtask

  // mode 0: ready always high, 1: toggling, 2: random
  task automatic do_dump(input bit sel, input int mode, input string tag);
    int          q0, v0, h0;
    logic [63:0] word;
    logic        ok;
    q0 = byte_q.size(); v0 = valid_total; h0 = hold_err;
    word = sel ? exp_snap_alt : exp_snap_cnt;
    ok = 1'b0;
    out_ready = 1'b0;
    send_cmd(OP_DUMP, {7'($urandom), sel});
    for (int c = 0; c < 2000; c++) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~c[0] : 1'($urandom);
      @(negedge clk);
      if (!out_valid && cmd_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_finished"}, ok, 1'b1);
    check({tag, "_nbytes"}, 64'(byte_q.size() - q0), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (q0 + k < byte_q.size())
        check($sformatf("%s_byte%0d", tag, k), byte_q[q0+k], word[63-8*k -: 8]);
    end
    if (mode == 0) check({tag, "_valid_cycles"}, 64'(valid_total - v0), 64'd8);
    check({tag, "_hold_while_stalled"}, 64'(hold_err - h0), 64'd0);
    check({tag, "_cmd_ready_after"}, cmd_ready, 1'b1);
  endtask

  initial begin
    int e0, d0, c0;
    int d;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_outputs", {cnt_clr, cnt_en, alt_load, alt_en, done, out_valid}, 6'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: CLEAR then RUN of 5
    do_clear();
    do_run(5, 1'b0, "t1");
    check("t1_cnt", cnt_m, 64'd5);
    check("t1_alt", alt_m, 64'hFFFF_FFFF_FFFF_FFFB);

    // 2: DUMP alt, ready high
    do_dump(1'b1, 0, "t2");
    // 3: DUMP cnt, ready toggling
    do_dump(1'b0, 1, "t3");

    // 4: zero-length run
    e0 = en_total; d0 = done_total;
    send_cmd(OP_SETDUR, 8'h00);
    send_cmd(OP_SETDUR, 8'h00);
    send_cmd(OP_RUN, 8'h00);
    check("t4_done_next_cycle", done, 1'b1);
    wait_idle();
    check("t4_en_cycles", 64'(en_total - e0), 64'd0);
    check("t4_done_pulses", 64'(done_total - d0), 64'd1);
    exp_snap_cnt = exp_cnt;
    exp_snap_alt = exp_alt;
    do_dump(1'b0, 2, "t4c");
    do_dump(1'b1, 2, "t4a");

    // 5: CLEAR held during a RUN of 5
    send_cmd(OP_SETDUR, 8'h00);
    send_cmd(OP_SETDUR, 8'h05);
    e0 = en_total; c0 = clr_total;
    send_cmd(OP_RUN, 8'h00);
    send_cmd(OP_CLEAR, 8'h00);
    wait_idle();
    check("t5_en_cycles", 64'(en_total - e0), 64'd5);
    check("t5_clr_after_run", 64'(en_at_clr - e0), 64'd5);
    check("t5_clr_pulses", 64'(clr_total - c0), 64'd1);
    exp_cnt = exp_cnt + 64'd5;
    exp_alt = exp_alt - 64'd5;
    exp_snap_cnt = exp_cnt;
    exp_snap_alt = exp_alt;
    exp_alt = exp_cnt;
    exp_cnt = '0;
    check("t5_cnt_cleared", cnt_m, exp_cnt);
    do_dump(1'b1, 2, "t5a");

    // 6: reset in the middle of a DUMP
    out_ready = 1'b1;
    send_cmd(OP_DUMP, 8'h01);
    @(negedge clk);
    check("t6_streaming", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_out_valid", out_valid, 1'b0);
    check("t6_async_outputs", {cnt_clr, cnt_en, alt_load, alt_en, done, busy}, 6'b0);
    check("t6_async_cmd_ready", cmd_ready, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_snap_cnt = '0;
    exp_snap_alt = '0;
    do_dump(1'b0, 0, "t6c");
    do_dump(1'b1, 0, "t6a");
    // dur was reset too: a bare RUN has no enabled cycles
    e0 = en_total;
    send_cmd(OP_RUN, 8'h00);
    wait_idle();
    check("t6_run_dur0", 64'(en_total - e0), 64'd0);
    exp_snap_cnt = exp_cnt;
    exp_snap_alt = exp_alt;
    do_dump(1'b1, 2, "t6r");

    // Randomized sequences
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) == 1) do_clear();
      d = $urandom_range(0, 12);
      do_run(d, 1'($urandom), $sformatf("r%0d", it));
      do_dump(1'($urandom), $urandom_range(0, 2), $sformatf("r%0d_d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
